// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings and default width.
package div_defs;

  localparam int unsigned DIV_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage : div_defs

// File: rtl/seq_restoring_divider_if.sv
// Start/done request and result bus between the requester and the divider.
interface seq_restoring_divider_if #(
  parameter int unsigned N = 4
);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface : seq_restoring_divider_if

// File: rtl/seq_restoring_divider_trial_sub.sv
// Ripple full-adder subtractor a - b = a + ~b + 1; cout=1 means a >= b (no borrow).
module div_trial_sub #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         cout
);

  logic [W-1:0] nb;
  logic [W:0]   carry;

  assign nb       = ~b;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i]    = a[i] ^ nb[i] ^ carry[i];
    assign carry[i+1] = (a[i] & nb[i]) | (carry[i] & (a[i] ^ nb[i]));
  end

  assign cout = carry[W];

endmodule : div_trial_sub

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial-subtract step per clock, start/done handshake.
module seq_restoring_divider
  import div_defs::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  div_if
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned TW = N + 1;

  div_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  r_q, r_d, q_q, q_d, d_q, d_d;
  logic [N-1:0]  quot_q, quot_d, rem_q, rem_d;
  logic          busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic [TW-1:0] trial_c, diff_c;
  logic          cout_c;
  logic          unused_diff_msb_c;

  assign trial_c = {r_q, q_q[N-1]};

  div_trial_sub #(.W(TW)) u_trial_sub (
    .a    (trial_c),
    .b    ({1'b0, d_q}),
    .diff (diff_c),
    .cout (cout_c)
  );

  // Kept differences are below D, so the MSB of diff is zero whenever it is used.
  assign unused_diff_msb_c = diff_c[TW-1];

  // Next-state, datapath step and result capture.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (div_if.start) begin
          state_d = ST_RUN;
          d_d     = div_if.divisor;
          q_d     = div_if.dividend;
          r_d     = '0;
          count_d = '0;
          dbz_d   = (div_if.divisor == '0);
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        r_d     = cout_c ? diff_c[N-1:0] : trial_c[N-1:0];
        q_d     = {q_q[N-2:0], cout_c};
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          state_d = ST_DONE;
          quot_d  = q_d;
          rem_d   = r_d;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign div_if.busy        = busy_q;
  assign div_if.done        = done_q;
  assign div_if.quotient    = quot_q;
  assign div_if.remainder   = rem_q;
  assign div_if.div_by_zero = dbz_q;

endmodule : seq_restoring_divider

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive self-checking bench for seq_restoring_divider (N=4).
module tb_seq_restoring_divider;

  localparam int unsigned N = 4;
  localparam int LAT = 4;     // edges from the accepting edge to the first sample showing done
  localparam int MAXW = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_pulses = 0;

  seq_restoring_divider_if #(.N(N)) div_if ();

  seq_restoring_divider #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (div_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (div_if.done) done_pulses++;

  // Issue one request, wait for done (bounded), then step once more so the DUT is back in IDLE.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic [N-1:0] r,
                         output logic dbz, output int lat, output int busy_cycles);
    @(negedge clk);
    div_if.start    = 1'b1;
    div_if.dividend = a;
    div_if.divisor  = b;
    @(posedge clk); #1;
    div_if.start = 1'b0;
    lat = 0;
    busy_cycles = 0;
    while (!div_if.done && lat < MAXW) begin
      if (div_if.busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    if (div_if.busy) busy_cycles++;
    q   = div_if.quotient;
    r   = div_if.remainder;
    dbz = div_if.div_by_zero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [3*N+2:0] outs;
    rst_n = 1'b0;
    #1;
    outs = {div_if.busy, div_if.done, div_if.div_by_zero, div_if.quotient, div_if.remainder, div_if.quotient};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0", outs);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({div_if.busy, div_if.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle_no_start: busy/done got %b, expected 00", {div_if.busy, div_if.done});
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] q, r; logic dbz; int lat, bc;
    run_div(4'd13, 4'd3, q, r, dbz, lat, bc);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d, expected %0d", lat, LAT); end
    n_checks++; if (bc !== LAT) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d, expected %0d", bc, LAT); end
    n_checks++; if (q !== 4'd4) begin n_fail++; $display("FAIL basic_quotient: got %0d, expected 4", q); end
    n_checks++; if (r !== 4'd1) begin n_fail++; $display("FAIL basic_remainder: got %0d, expected 1", r); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %0b, expected 0", dbz); end
  endtask

  task automatic test_vectors();
    logic [N-1:0] va[3] = '{4'd15, 4'd7, 4'd0};
    logic [N-1:0] vb[3] = '{4'd1,  4'd9, 4'd5};
    logic [N-1:0] vq[3] = '{4'd15, 4'd0, 4'd0};
    logic [N-1:0] vr[3] = '{4'd0,  4'd7, 4'd0};
    logic [N-1:0] q, r; logic dbz; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_div(va[i], vb[i], q, r, dbz, lat, bc);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL vec%0d_latency: got %0d, expected %0d", i, lat, LAT); end
      n_checks++; if (q !== vq[i]) begin n_fail++; $display("FAIL vec%0d_quotient: got %0d, expected %0d", i, q, vq[i]); end
      n_checks++; if (r !== vr[i]) begin n_fail++; $display("FAIL vec%0d_remainder: got %0d, expected %0d", i, r, vr[i]); end
      n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL vec%0d_dbz: got %0b, expected 0", i, dbz); end
    end
  endtask

  task automatic test_div_by_zero();
    logic [N-1:0] q, r; logic dbz; int lat, bc;
    run_div(4'd9, 4'd0, q, r, dbz, lat, bc);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL dbz_latency: got %0d, expected %0d", lat, LAT); end
    n_checks++; if (q !== 4'd15) begin n_fail++; $display("FAIL dbz_quotient: got %0d, expected 15", q); end
    n_checks++; if (r !== 4'd9) begin n_fail++; $display("FAIL dbz_remainder: got %0d, expected 9", r); end
    n_checks++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %0b, expected 1", dbz); end
  endtask

  task automatic test_start_ignored();
    int lat, bc;
    @(negedge clk);
    div_if.start = 1'b1; div_if.dividend = 4'd12; div_if.divisor = 4'd5;
    @(posedge clk); #1;
    div_if.start = 1'b0;
    @(posedge clk); #1;
    div_if.start = 1'b1; div_if.dividend = 4'd2; div_if.divisor = 4'd1;
    @(posedge clk); #1;
    div_if.start = 1'b0;
    lat = 2;
    bc = 2;
    while (!div_if.done && lat < MAXW) begin
      if (div_if.busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    if (div_if.busy) bc++;
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL ignore_latency: got %0d, expected %0d", lat, LAT); end
    n_checks++; if (bc !== LAT) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d, expected %0d", bc, LAT); end
    n_checks++; if (div_if.quotient !== 4'd2) begin n_fail++; $display("FAIL ignore_quotient: got %0d, expected 2", div_if.quotient); end
    n_checks++; if (div_if.remainder !== 4'd2) begin n_fail++; $display("FAIL ignore_remainder: got %0d, expected 2", div_if.remainder); end
    @(posedge clk); #1;
    n_checks++;
    if ({div_if.busy, div_if.done} !== 2'b00) begin
      n_fail++; $display("FAIL ignore_back_to_idle: busy/done got %b, expected 00", {div_if.busy, div_if.done});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({div_if.busy, div_if.done} !== 2'b00) begin
      n_fail++; $display("FAIL ignore_no_second_run: busy/done got %b, expected 00", {div_if.busy, div_if.done});
    end
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] q, r; logic dbz; int lat, bc, pulses0;
    @(negedge clk);
    div_if.start = 1'b1; div_if.dividend = 4'd9; div_if.divisor = 4'd0;
    @(posedge clk); #1;
    div_if.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if ({div_if.busy, div_if.div_by_zero} !== 2'b11) begin
      n_fail++; $display("FAIL midrst_pre_state: busy/dbz got %b, expected 11", {div_if.busy, div_if.div_by_zero});
    end
    pulses0 = done_pulses;
    rst_n = 1'b0;
    #1;
    n_checks++; if (div_if.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b, expected 0", div_if.busy); end
    n_checks++; if (div_if.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL midrst_dbz: got %0b, expected 0", div_if.div_by_zero); end
    n_checks++; if (div_if.quotient !== 4'd0) begin n_fail++; $display("FAIL midrst_quotient: got %0d, expected 0", div_if.quotient); end
    n_checks++; if (div_if.remainder !== 4'd0) begin n_fail++; $display("FAIL midrst_remainder: got %0d, expected 0", div_if.remainder); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++;
    if (done_pulses !== pulses0) begin
      n_fail++; $display("FAIL midrst_no_done: got %0d pulses, expected %0d", done_pulses, pulses0);
    end
    run_div(4'd6, 4'd4, q, r, dbz, lat, bc);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL midrst_after_latency: got %0d, expected %0d", lat, LAT); end
    n_checks++; if (q !== 4'd1) begin n_fail++; $display("FAIL midrst_after_quotient: got %0d, expected 1", q); end
    n_checks++; if (r !== 4'd2) begin n_fail++; $display("FAIL midrst_after_remainder: got %0d, expected 2", r); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] q, r, eq, er; logic dbz; int lat, bc, pulses0;
    pulses0 = done_pulses;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        eq = (b == 0) ? 4'd15 : N'(a / b);
        er = (b == 0) ? N'(a) : N'(a % b);
        run_div(N'(a), N'(b), q, r, dbz, lat, bc);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL exh_latency %0d/%0d: got %0d, expected %0d", a, b, lat, LAT); end
        n_checks++; if (q !== eq) begin n_fail++; $display("FAIL exh_quotient %0d/%0d: got %0d, expected %0d", a, b, q, eq); end
        n_checks++; if (r !== er) begin n_fail++; $display("FAIL exh_remainder %0d/%0d: got %0d, expected %0d", a, b, r, er); end
        n_checks++; if (dbz !== (b == 0)) begin n_fail++; $display("FAIL exh_dbz %0d/%0d: got %0b, expected %0b", a, b, dbz, (b == 0)); end
      end
    end
    @(negedge clk);
    n_checks++;
    if (done_pulses - pulses0 !== 256) begin
      n_fail++; $display("FAIL exh_done_count: got %0d, expected 256", done_pulses - pulses0);
    end
  endtask

  initial begin
    div_if.start    = 1'b0;
    div_if.dividend = '0;
    div_if.divisor  = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_by_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_restoring_divider
